bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/arvi_bus_pkg.sv | 18 +
 rtl/bus_if.sv | 23 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/bus_arb.sv | 138 +++++++++++++
 tb/tb_bus_arb.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arvi_bus_pkg.sv
// Shared types and sizing helpers for the bus arbiter: FSM state encoding,
// data/byte-enable widths and the channel-index width function.
package arvi_bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int DW  = 32;
   localparam int BEW = 4;

   // Index width for n channels; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_if.sv
// Single-master bus: request side is driven by the arbiter, the slave returns
// ack and read data.
interface bus_if #(
   parameter int AW = 32
);
   logic          bus_en;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic [AW-1:0] addr;
   logic [3:0]    byte_en;
   logic          ack;
   logic [31:0]   rd_data;

   modport master (
      output bus_en, wr_en, wr_data, addr, byte_en,
      input  ack, rd_data
   );

   modport slave (
      input  bus_en, wr_en, wr_data, addr, byte_en,
      output ack, rd_data
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 (mod NCH)
// upwards and returns the first requesting channel as one-hot and as index.
module rr_arbiter #(
   parameter int NCH = 2,
   parameter int IW  = 1
)(
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  last_grant,
   output logic           valid,
   output logic [NCH-1:0] grant,
   output logic [IW-1:0]  grant_idx
);

   logic          found;
   logic [IW:0]   cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NCH; k++) begin
         // last_grant < NCH and k <= NCH, so one subtraction wraps correctly
         cand = {1'b0, last_grant} + (IW+1)'(k);
         if (cand >= (IW+1)'(NCH)) begin
            cand = cand - (IW+1)'(NCH);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found                  = 1'b1;
            grant[cand[IW-1:0]]    = 1'b1;
            grant_idx              = cand[IW-1:0];
         end
      end
      valid = found;
   end

endmodule

// File: rtl/bus_arb.sv
// Round-robin arbiter granting NCH requesters access to one bus master port.
// Optional BUSY watchdog is built when ARVI_BUS_TIMEOUT_EN is defined.
module bus_arb
   import arvi_bus_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
)(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NCH-1:0]           i_req,
   input  logic [NCH-1:0]           i_wr_en,
   input  logic [NCH-1:0][AW-1:0]   i_addr,
   input  logic [NCH-1:0][DW-1:0]   i_wr_data,
   input  logic [NCH-1:0][BEW-1:0]  i_byte_en,
   output logic [NCH-1:0]           o_ready,
   output logic [DW-1:0]            o_rd_data,
   output logic [NCH-1:0]           o_err,
   bus_if.master                    bus_m
);

   localparam int IW = idx_width(NCH);

   state_t          state_reg, state_next;
   logic [IW-1:0]   last_grant_reg;
   logic [NCH-1:0]  grant_oh_reg;
   logic            arb_valid;
   logic [NCH-1:0]  arb_grant;
   logic [IW-1:0]   arb_idx;

   logic            bus_en_reg, wr_en_reg;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wr_data_reg;
   logic [BEW-1:0]  byte_en_reg;

   logic            tmo_hit;
   logic            done;
   logic            err_evt;
   logic            owner_req;

   rr_arbiter #(.NCH(NCH), .IW(IW)) u_rr (
      .req        (i_req),
      .last_grant (last_grant_reg),
      .valid      (arb_valid),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (arb_valid) state_next = BUSY;
         BUSY: if (bus_m.ack || tmo_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Responses are only offered to a channel that is still asking for them.
   assign owner_req = |(grant_oh_reg & i_req);

   always_comb begin
      done      = 1'b0;
      err_evt   = 1'b0;
      o_rd_data = '0;
      if (i_rst && state_reg == BUSY) begin
         done    = bus_m.ack | tmo_hit;
         err_evt = tmo_hit & ~bus_m.ack;
         if (bus_m.ack && !wr_en_reg && owner_req) begin
            o_rd_data = bus_m.rd_data;
         end
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_resp
      assign o_ready[gi] = done    & grant_oh_reg[gi] & i_req[gi];
      assign o_err[gi]   = err_evt & grant_oh_reg[gi] & i_req[gi];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         last_grant_reg <= IW'(NCH-1);
         grant_oh_reg   <= '0;
         bus_en_reg     <= 1'b0;
         wr_en_reg      <= 1'b0;
         addr_reg       <= '0;
         wr_data_reg    <= '0;
         byte_en_reg    <= '0;
      end else if (state_reg == IDLE && arb_valid) begin
         last_grant_reg <= arb_idx;
         grant_oh_reg   <= arb_grant;
         bus_en_reg     <= 1'b1;
         wr_en_reg      <= i_wr_en[arb_idx];
         wr_data_reg    <= i_wr_data[arb_idx];
         byte_en_reg    <= i_byte_en[arb_idx];
         // Writes are word-aligned on the bus; reads keep the byte address.
         addr_reg       <= i_wr_en[arb_idx] ? {i_addr[arb_idx][AW-1:2], 2'b00}
                                            : i_addr[arb_idx];
      end else if (state_reg == BUSY && (bus_m.ack || tmo_hit)) begin
         bus_en_reg     <= 1'b0;
         wr_en_reg      <= 1'b0;
      end
   end

`ifdef ARVI_BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt_reg;

   // Counter holds k-1 during BUSY cycle k, so the limit fires on cycle TIMEOUT.
   always_ff @(posedge i_clk) begin
      if (!i_rst || state_reg == IDLE) begin
         tmo_cnt_reg <= '0;
      end else if (!tmo_hit) begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end

   assign tmo_hit = (state_reg == BUSY) && (tmo_cnt_reg == CW'(TIMEOUT - 1));
`else
   localparam bit TMO_BUILD = 1'b0;
   assign tmo_hit = TMO_BUILD && (TIMEOUT > 0);
`endif

   assign bus_m.bus_en  = bus_en_reg;
   assign bus_m.wr_en   = wr_en_reg;
   assign bus_m.addr    = addr_reg;
   assign bus_m.wr_data = wr_data_reg;
   assign bus_m.byte_en = byte_en_reg;

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares whenever o_ready/o_err fire.
module tb_bus_arb;
   import arvi_bus_pkg::*;

   localparam int NCH     = 2;
   localparam int AW      = 32;
   localparam int TIMEOUT = 8;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NCH-1:0]          req;
   logic [NCH-1:0]          wr_en;
   logic [NCH-1:0][AW-1:0]  addr;
   logic [NCH-1:0][31:0]    wdata;
   logic [NCH-1:0][3:0]     be;
   logic [NCH-1:0]          o_ready;
   logic [31:0]             o_rd_data;
   logic [NCH-1:0]          o_err;

   bus_if #(.AW(AW)) bus ();

   bus_arb #(.NCH(NCH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .i_clk     (clk),
      .i_rst     (rst_n),
      .i_req     (req),
      .i_wr_en   (wr_en),
      .i_addr    (addr),
      .i_wr_data (wdata),
      .i_byte_en (be),
      .o_ready   (o_ready),
      .o_rd_data (o_rd_data),
      .o_err     (o_err),
      .bus_m     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0] ready;
      logic [NCH-1:0] err;
      logic [31:0]    rd;
      string          tag;
   } resp_t;

   resp_t exp_q[$];
   resp_t mon_e;
   int    n_pass  = 0;
   int    n_total = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endfunction

   // Response monitor: every ready/err pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (o_ready != '0 || o_err != '0) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_resp: got ready=%b err=%b rd=0x%08h, want no response",
                     o_ready, o_err, o_rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, "_ready"}, 32'(o_ready), 32'(mon_e.ready));
            check({mon_e.tag, "_err"},   32'(o_err),   32'(mon_e.err));
            check({mon_e.tag, "_rdata"}, o_rd_data,    mon_e.rd);
            $display("txn %s: ready=%b err=%b rd_data=0x%08h", mon_e.tag, o_ready, o_err, o_rd_data);
         end
      end else begin
         check("quiet_rd_data", o_rd_data, 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [NCH-1:0] r, logic [NCH-1:0] e, logic [31:0] d, string tag);
      resp_t x;
      x.ready = r;
      x.err   = e;
      x.rd    = d;
      x.tag   = tag;
      exp_q.push_back(x);
   endtask

   task automatic bus_ack(logic [31:0] d);
      bus.ack     = 1'b1;
      bus.rd_data = d;
   endtask

   task automatic bus_idle();
      bus.ack     = 1'b0;
      bus.rd_data = 32'h0;
   endtask

   // One complete transaction on channel ch with ack in BUSY cycle dly.
   task automatic txn(int ch, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b,
                      int dly, logic [31:0] rdv, logic [31:0] exp_a, string tag);
      req[ch]   = 1'b1;
      wr_en[ch] = w;
      addr[ch]  = a;
      wdata[ch] = d;
      be[ch]    = b;
      tick();
      check({tag, "_bus_en"}, 32'(bus.bus_en), 32'h1);
      check({tag, "_addr"},   bus.addr,        exp_a);
      check({tag, "_wr_en"},  32'(bus.wr_en),  32'(w));
      check({tag, "_be"},     32'(bus.byte_en), 32'(b));
      if (w) check({tag, "_wdata"}, bus.wr_data, d);
      repeat (dly - 1) tick();
      check({tag, "_addr_held"}, bus.addr, exp_a);
      push(NCH'(1) << ch, '0, w ? 32'h0 : rdv, tag);
      bus_ack(rdv);
      tick();
      bus_idle();
      req[ch] = 1'b0;
      check({tag, "_bus_en_clr"}, 32'(bus.bus_en), 32'h0);
      check({tag, "_wr_en_clr"},  32'(bus.wr_en),  32'h0);
      tick();
   endtask

   task automatic wait_bus_en(string tag);
      int w;
      w = 0;
      while (!bus.bus_en && w < 10) begin
         tick();
         w++;
      end
      if (!bus.bus_en) begin
         n_total++;
         $display("FAIL %s_grant_wait: got no bus_en within 10 cycles, want grant", tag);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      req         = '0;
      wr_en       = '0;
      addr        = '0;
      wdata       = '0;
      be          = '0;
      bus.ack     = 1'b0;
      bus.rd_data = 32'h0;

      tick();
      tick();
      check("rst_bus_en", 32'(bus.bus_en), 32'h0);
      check("rst_wr_en",  32'(bus.wr_en),  32'h0);
      check("rst_addr",   bus.addr,        32'h0);
      check("rst_wdata",  bus.wr_data,     32'h0);
      check("rst_be",     32'(bus.byte_en), 32'h0);
      rst_n = 1'b1;
      tick();

      txn(0, 1'b0, 32'h0000_1003, 32'h0, 4'hF, 2, 32'hDEADBEEF, 32'h0000_1003, "rd_ch0");
      txn(1, 1'b1, 32'h0000_2007, 32'hCAFEF00D, 4'hF, 3, 32'h1234_5678, 32'h0000_2004, "wr_ch1");

      // Both channels request continuously: expect alternation starting at ch0.
      addr[0] = 32'h0000_0100;
      addr[1] = 32'h0000_0200;
      wr_en   = '0;
      be      = '{4'h3, 4'hC};
      req     = 2'b11;
      for (int i = 0; i < 4; i++) begin
         int exp_ch;
         exp_ch = i % 2;
         wait_bus_en($sformatf("rr%0d", i));
         check($sformatf("rr%0d_addr", i), bus.addr, (exp_ch == 0) ? 32'h100 : 32'h200);
         push(NCH'(1) << exp_ch, '0, 32'hA0 + 32'(i), $sformatf("rr%0d_ch%0d", i, exp_ch));
         bus_ack(32'hA0 + 32'(i));
         tick();
         bus_idle();
         check($sformatf("rr%0d_gap", i), 32'(bus.bus_en), 32'h0);
      end
      req = '0;
      tick();

      // Requester withdraws mid-transaction: bus completes, no response.
      req[1]   = 1'b1;
      wr_en[1] = 1'b0;
      addr[1]  = 32'h0000_0300;
      tick();
      check("drop_bus_en", 32'(bus.bus_en), 32'h1);
      tick();
      req[1] = 1'b0;
      bus_ack(32'h0000_0055);
      @(negedge clk);
      check("drop_ready", 32'(o_ready), 32'h0);
      tick();
      bus_idle();
      check("drop_bus_en_clr", 32'(bus.bus_en), 32'h0);
      tick();

      // Reset during a ch0 read, with ack arriving in the reset cycle.
      req[0]   = 1'b1;
      wr_en[0] = 1'b0;
      addr[0]  = 32'h0000_0400;
      tick();
      check("rstb_bus_en", 32'(bus.bus_en), 32'h1);
      rst_n = 1'b0;
      bus_ack(32'h0000_0077);
      @(negedge clk);
      check("rstb_ready", 32'(o_ready), 32'h0);
      tick();
      check("rstb_bus_en_clr", 32'(bus.bus_en), 32'h0);
      bus_idle();
      rst_n  = 1'b1;
      req[0] = 1'b0;
      tick();
      addr[0] = 32'h0000_0500;
      addr[1] = 32'h0000_0600;
      req     = 2'b11;
      tick();
      check("rstb_regrant_addr", bus.addr, 32'h0000_0500);
      push(2'b01, 2'b00, 32'h0000_0088, "rstb_regrant");
      bus_ack(32'h0000_0088);
      tick();
      bus_idle();
      req = '0;
      tick();

      // Unacknowledged read: watchdog behaviour depends on the build.
      req[0]   = 1'b1;
      wr_en[0] = 1'b0;
      addr[0]  = 32'h0000_0700;
      tick();
`ifdef ARVI_BUS_TIMEOUT_EN
      repeat (TIMEOUT - 2) tick();
      check("tmo_cyc7_bus_en", 32'(bus.bus_en), 32'h1);
      check("tmo_cyc7_err",    32'(o_err),      32'h0);
      push(2'b01, 2'b01, 32'h0, "timeout");
      tick();
      tick();
      check("tmo_bus_en_clr", 32'(bus.bus_en), 32'h0);
      req[0] = 1'b0;
      tick();
`else
      repeat (99) tick();
      check("notmo_bus_en", 32'(bus.bus_en), 32'h1);
      check("notmo_ready",  32'(o_ready),    32'h0);
      check("notmo_err",    32'(o_err),      32'h0);
      push(2'b01, 2'b00, 32'h0000_0099, "late_ack");
      bus_ack(32'h0000_0099);
      tick();
      bus_idle();
      req[0] = 1'b0;
      check("late_ack_bus_en_clr", 32'(bus.bus_en), 32'h0);
      tick();
`endif

      // Ack in IDLE must be ignored.
      bus_ack(32'h0000_00EE);
      tick();
      bus_idle();
      check("idle_ack_bus_en", 32'(bus.bus_en), 32'h0);

      tick();
      tick();
      check("pending_resps", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
